// File: rtl/present_inv_sbox_keystrip.sv
// PRESENT inverse S-box layer with round-key strip.
// Nibble-serial: one InvS lookup per cycle, LSB nibble first.
module present_inv_sbox_keystrip #(
  parameter int NIBBLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [4*NIBBLES-1:0]   io_in_state,
  input  logic [4*NIBBLES-1:0]   io_in_key,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [4*NIBBLES-1:0]   io_out,
  output logic                   io_busy
);

  localparam int W = 4 * NIBBLES;
  localparam logic [3:0] LAST = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  st_t          r_st;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_state;
  logic [W-1:0] r_key;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [3:0]   w_nib;
  logic [3:0]   w_sub;

  function automatic logic [3:0] inv_s(
    input logic [3:0] x
  );
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      4'hF: y = 4'hA;
    endcase
    return y;
  endfunction

  assign w_nib = r_state[3:0] ^ r_key[3:0];
  assign w_sub = inv_s(w_nib);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st        <= IDLE;
      r_cnt       <= 4'd0;
      r_state     <= '0;
      r_key       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (io_in_valid) begin
            r_state    <= io_in_state;
            r_key      <= io_in_key;
            r_cnt      <= 4'd0;
            r_st       <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          // Result enters at the top; after NIBBLES shifts it lands in place.
          r_state <= {w_sub, r_state[W-1:4]};
          r_key   <= {4'h0, r_key[W-1:4]};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == LAST) begin
            r_st        <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            r_st        <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_st        <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign io_in_ready  = r_in_ready;
  assign io_out_valid = r_out_valid;
  assign io_busy      = r_busy;
  assign io_out       = r_state;

endmodule

// File: tb/tb_present_inv_sbox_keystrip.sv
// Directed vectors, random round-trip and handshake corner cases
// for present_inv_sbox_keystrip.
module tb_present_inv_sbox_keystrip;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [63:0] io_in_state = '0;
  logic [63:0] io_in_key = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [63:0] io_out;
  logic        io_busy;

  int n_tests = 0;
  int n_fail  = 0;

  present_inv_sbox_keystrip #(.NIBBLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_state (io_in_state),
    .io_in_key   (io_in_key),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out      (io_out),
    .io_busy     (io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] s;
    logic [63:0] k;
    logic [63:0] e;
  } vec_t;

  vec_t vecs[5];

  // Forward PRESENT S-box, used only to build round-trip stimulus.
  logic [3:0] fwd_s[16] = '{4'hC, 4'h5, 4'h6, 4'hB,
                            4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8,
                            4'h4, 4'h7, 4'h1, 4'h2};

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!io_in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!io_in_ready) check("in_ready_timeout", 64'(io_in_ready), 64'd1);
  endtask

  // Accept a block and return the cycle count until io_out_valid.
  task automatic start_block(input logic [63:0] s,
                             input logic [63:0] k,
                             output int lat);
    wait_ready();
    io_in_valid = 1'b1;
    io_in_state = s;
    io_in_key   = k;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    io_in_state = ~s;
    io_in_key   = ~k;
    lat = 0;
    while (!io_out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic finish_block(output logic [63:0] res);
    res = io_out;
    @(negedge clock);
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic [63:0] x, k, s, held;
    logic        bp_ok;

    vecs[0] = '{64'h0, 64'h0, 64'h5555555555555555};
    vecs[1] = '{64'h0123456789ABCDEF, 64'h0, 64'h5EF8C12DB463079A};
    vecs[2] = '{64'hCCCCCCCCCCCCCCCC, 64'hFFFFFFFFFFFFFFFF,
                64'h8888888888888888};
    vecs[3] = '{64'hFEDCBA9876543210, 64'h0123456789ABCDEF,
                64'hAAAAAAAAAAAAAAAA};
    vecs[4] = '{64'h0, 64'h0123456789ABCDEF, 64'h5EF8C12DB463079A};

    #12;
    check("rst_in_ready", 64'(io_in_ready), 64'd1);
    check("rst_out_valid", 64'(io_out_valid), 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);
    check("rst_out", io_out, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      start_block(vecs[i].s, vecs[i].k, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
      finish_block(res);
      check($sformatf("vec%0d_out", i), res, vecs[i].e);
      check($sformatf("vec%0d_idle_ready", i), 64'(io_in_ready), 64'd1);
    end

    // Backpressure: 20 cycles with io_out_ready low.
    start_block(64'h0123456789ABCDEF, 64'h0, lat);
    held  = io_out;
    bp_ok = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (!io_out_valid || io_out !== held || io_in_ready || io_busy)
        bp_ok = 1'b0;
    end
    check("bp_hold", 64'(bp_ok), 64'd1);
    check("bp_out", io_out, 64'h5EF8C12DB463079A);
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
    check("bp_release_ready", 64'(io_in_ready), 64'd1);
    check("bp_release_valid", 64'(io_out_valid), 64'd0);

    // New data offered during RUN must be ignored.
    wait_ready();
    io_in_valid = 1'b1;
    io_in_state = 64'hCCCCCCCCCCCCCCCC;
    io_in_key   = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clock);
    #1;
    check("run_busy", 64'(io_busy), 64'd1);
    check("run_in_ready", 64'(io_in_ready), 64'd0);
    io_in_state = 64'h0123456789ABCDEF;
    io_in_key   = 64'h0;
    lat = 0;
    while (!io_out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      io_in_valid = ~io_in_valid;
      lat++;
    end
    io_in_valid = 1'b0;
    check("ign_latency", 64'(lat), 64'd16);
    finish_block(res);
    check("ign_out", res, 64'h8888888888888888);

    // Asynchronous reset in the middle of RUN.
    wait_ready();
    io_in_valid = 1'b1;
    io_in_state = 64'h0123456789ABCDEF;
    io_in_key   = 64'h0;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_in_ready", 64'(io_in_ready), 64'd1);
    check("arst_out_valid", 64'(io_out_valid), 64'd0);
    check("arst_busy", 64'(io_busy), 64'd0);
    check("arst_out", io_out, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    start_block(64'hFEDCBA9876543210, 64'h0123456789ABCDEF, lat);
    check("arst_next_latency", 64'(lat), 64'd16);
    finish_block(res);
    check("arst_next_out", res, 64'hAAAAAAAAAAAAAAAA);

    // Round-trip: forward S-box then key add, recover original.
    for (int b = 0; b < 1000; b++) begin
      x = {$urandom, $urandom};
      k = {$urandom, $urandom};
      for (int n = 0; n < 16; n++)
        s[4*n +: 4] = fwd_s[x[4*n +: 4]] ^ k[4*n +: 4];
      start_block(s, k, lat);
      if (lat != 16) check("rt_latency", 64'(lat), 64'd16);
      finish_block(res);
      check($sformatf("rt%0d", b), res, x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1);
  end

endmodule

// File: doc/present_inv_sbox_keystrip.md
PRESENT_INV_SBOX_KEYSTRIP -- requirements
Module: present_inv_sbox_keystrip

Interface
REQ-001 SHALL provide parameter NIBBLES, default 16, number of 4-bit nibbles per block (block width W = 4*NIBBLES).
REQ-002 SHALL provide clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL provide io_in_valid  input  1  io_in_state/io_in_key are valid this cycle.
REQ-005 SHALL provide io_in_ready  output  1  block can accept a new block this cycle.
REQ-006 SHALL provide io_in_state  input  W  ciphertext-side state, i.e. forward S-box output XOR round key.
REQ-007 SHALL provide io_in_key  input  W  round key to strip.
REQ-008 SHALL provide io_out_valid  output  1  io_out holds a complete result.
REQ-009 SHALL provide io_out_ready  input  1  consumer accepts io_out this cycle.
REQ-010 SHALL provide io_out  output  W  recovered S-box input state.
REQ-011 SHALL provide io_busy  output  1  high while nibbles are being processed.

Function
REQ-012 SHALL compute, per nibble i, io_out[4i+3:4i] = InvS(io_in_state[4i+3:4i] XOR io_in_key[4i+3:4i]); inverse of forward "S-box then key XOR".
REQ-013 SHALL use InvS table (input 0..F): 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; one inverse S-box instance, nibble-serial.
REQ-015 SHALL assert io_in_ready only in IDLE; io_in_valid outside IDLE is ignored, inputs not sampled.
REQ-016 SHALL, on edge with io_in_valid & io_in_ready, load state and key registers, clear 4-bit-wide counter cnt to 0, enter RUN.
REQ-017 SHALL, on each RUN edge, process the least-significant nibble of state XOR key, shift state and key registers right by 4, insert InvS result at the most-significant nibble of state, increment cnt.
REQ-018 SHALL, on the RUN edge where cnt == NIBBLES-1, enter DONE; io_out_valid rises exactly NIBBLES cycles after the accepting edge.
REQ-019 SHALL drive io_out from the state register; value stable and io_out_valid high throughout DONE until handshake.
REQ-020 SHALL, on edge with io_out_valid & io_out_ready, return to IDLE; io_in_ready rises next cycle (no same-cycle reaccept).
REQ-021 SHALL hold DONE indefinitely while io_out_ready low (backpressure, no data loss).
REQ-022 SHALL drive io_busy = 1 exactly in RUN; io_out_valid = 1 exactly in DONE.
REQ-023 SHALL ignore io_out_ready outside DONE.
REQ-024 SHALL achieve throughput of one block per NIBBLES+2 cycles with io_out_ready held high.

Reset
REQ-025 SHALL, while reset low, force IDLE, cnt = 0, state/key registers = 0, io_in_ready = 1 (once reset released), io_out_valid = 0, io_busy = 0, io_out = 0.
REQ-026 SHALL abort any RUN or DONE immediately on reset assertion, discarding partial results, no output handshake.
REQ-027 SHALL accept a new block on the first rising edge after reset deasserts if io_in_valid high.

Verification
REQ-028 SHALL cover: state=0, key=0 -> io_out=0x5555555555555555 after 16 cycles.
REQ-029 SHALL cover: state=0x0123456789ABCDEF, key=0 -> io_out=0x5EF8C12DB463079A.
REQ-030 SHALL cover: state=0xCCCCCCCCCCCCCCCC, key=0xFFFFFFFFFFFFFFFF -> io_out=0x8888888888888888; round-trip against forward S-box+key-add model on 1000 random blocks -> original inputs recovered.
REQ-031 SHALL cover: io_out_ready held low 20 cycles in DONE -> io_out_valid stays high, io_out unchanged, io_in_ready low; release -> IDLE next cycle.
REQ-032 SHALL cover: io_in_valid toggled with new data during RUN -> ignored, result matches first block only.
REQ-033 SHALL cover: reset pulsed low at cnt=7 -> all outputs return to reset values asynchronously; next accepted block computes correctly with no residue.
